// File: rtl/mc_pkg.sv
// Shared constants, core index type and active-core decode for the multi-core
// multiplier processor's instruction fetch path.
package mc_pkg;

    localparam int NUM_CORES = 4;
    localparam int ADDR_W    = 8;
    localparam int INS_W     = 8;

    typedef logic [1:0] core_t;

    // A core_sel of 1..4 enables cores 0..core_sel-1. Any other value enables all cores.
    function automatic logic [NUM_CORES-1:0] active_mask(input logic [2:0] sel);
        case (sel)
            3'd1:    active_mask = 4'b0001;
            3'd2:    active_mask = 4'b0011;
            3'd3:    active_mask = 4'b0111;
            default: active_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter. The search for a grant starts one past the
// last core that was granted. No state changes while no core is eligible.
module rr_arbiter4
    import mc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CORES-1:0] i_elig,
    output logic [NUM_CORES-1:0] o_grant,
    output core_t                o_grant_idx,
    output logic                 o_any_grant
);

    core_t r_last;

    always_comb begin
        core_t w_cand;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            w_cand = r_last + core_t'(k);
            if (!o_any_grant && i_elig[w_cand]) begin
                o_any_grant = 1'b1;
                o_grant_idx = w_cand;
            end
        end
        o_grant = o_any_grant ? (NUM_CORES'(1) << o_grant_idx) : '0;
    end

    // The reset value of 3 gives core 0 priority for the first grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= core_t'(3);
        end else if (o_any_grant) begin
            r_last <= o_grant_idx;
        end
    end

endmodule

// File: rtl/ins_fetch_responder.sv
// Memory-side instruction fetch responder. One shared 1-cycle IRAM serves up
// to four cores round-robin, and each fetch returns with a valid strobe 2 cycles later.
module ins_fetch_responder
    import mc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2:0]                  core_sel,
    input  logic [NUM_CORES-1:0]        fetch_req,
    input  logic [NUM_CORES*ADDR_W-1:0] fetch_addr,
    input  logic [NUM_CORES-1:0]        end_op,
    output logic                        mem_en,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [INS_W-1:0]            mem_rdata,
    output logic [INS_W-1:0]            ins1,
    output logic [INS_W-1:0]            ins2,
    output logic [INS_W-1:0]            ins3,
    output logic [INS_W-1:0]            ins4,
    output logic [NUM_CORES-1:0]        ins_valid,
    output logic                        all_done,
    output logic [CNT_W-1:0]            fetch_count
);

    logic [NUM_CORES-1:0] w_active;
    logic [NUM_CORES-1:0] w_elig;
    logic [NUM_CORES-1:0] w_grant;
    logic [NUM_CORES-1:0] w_clr;
    core_t                w_grant_idx;
    logic                 w_any_grant;
    logic [ADDR_W-1:0]    w_grant_addr;
    logic                 w_done_next;

    logic [ADDR_W-1:0]    r_last_addr;
    logic                 r_rd_vld;
    core_t                r_rd_idx;
    logic [NUM_CORES-1:0] r_inflight;
    logic [INS_W-1:0]     r_ins [NUM_CORES];
    logic [NUM_CORES-1:0] r_ins_valid;
    logic                 r_all_done;
    logic [CNT_W-1:0]     r_fetch_count;

    // Gating with rst_n keeps the IRAM quiet while reset is held with requests pending.
    assign w_active = active_mask(core_sel);
    assign w_elig   = fetch_req & w_active & ~end_op & ~r_inflight & {NUM_CORES{rst_n}};

    rr_arbiter4 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_elig      (w_elig),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    assign w_grant_addr = fetch_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
    assign mem_en       = w_any_grant;
    assign mem_addr     = w_any_grant ? w_grant_addr : r_last_addr;
    assign w_clr        = r_rd_vld ? (NUM_CORES'(1) << r_rd_idx) : '0;
    assign w_done_next  = ((end_op & w_active) == w_active) && (r_inflight == '0) && !w_any_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_addr   <= '0;
            r_rd_vld      <= 1'b0;
            r_rd_idx      <= '0;
            r_inflight    <= '0;
            r_ins_valid   <= '0;
            r_all_done    <= 1'b0;
            r_fetch_count <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_ins[i] <= '0;
            end
        end else begin
            r_rd_vld    <= w_any_grant;
            r_rd_idx    <= w_grant_idx;
            r_inflight  <= (r_inflight & ~w_clr) | w_grant;
            r_ins_valid <= w_clr;
            r_all_done  <= w_done_next;
            if (w_any_grant) begin
                r_last_addr <= w_grant_addr;
            end
            if (r_rd_vld) begin
                r_ins[r_rd_idx] <= mem_rdata;
            end
            if (w_any_grant && (r_fetch_count != '1)) begin
                r_fetch_count <= r_fetch_count + CNT_W'(1);
            end
        end
    end

    assign ins1        = r_ins[0];
    assign ins2        = r_ins[1];
    assign ins3        = r_ins[2];
    assign ins4        = r_ins[3];
    assign ins_valid   = r_ins_valid;
    assign all_done    = r_all_done;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_ins_fetch_responder.sv
// Directed bench for ins_fetch_responder. It plays the role of the IRAM and checks
// every cycle against a behavioural model, plus hand-computed literal expectations.
module tb_ins_fetch_responder;

    logic        clk;
    logic        rst_n;
    logic [2:0]  coreSel;
    logic [3:0]  fetchReq;
    logic [31:0] fetchAddr;
    logic [3:0]  endOp;
    logic        memEn;
    logic [7:0]  memAddr;
    logic [7:0]  memRdata;
    logic [7:0]  ins1, ins2, ins3, ins4;
    logic [3:0]  insValid;
    logic        allDone;
    logic [15:0] fetchCount;

    logic [7:0]  mem [256];
    int          checks;
    int          failures;
    int          cycle;
    bit          valid3Seen;

    ins_fetch_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .core_sel    (coreSel),
        .fetch_req   (fetchReq),
        .fetch_addr  (fetchAddr),
        .end_op      (endOp),
        .mem_en      (memEn),
        .mem_addr    (memAddr),
        .mem_rdata   (memRdata),
        .ins1        (ins1),
        .ins2        (ins2),
        .ins3        (ins3),
        .ins4        (ins4),
        .ins_valid   (insValid),
        .all_done    (allDone),
        .fetch_count (fetchCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // The bench stands in for a synchronous-read IRAM.
    always @(posedge clk) begin
        if (memEn) memRdata <= mem[memAddr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, actual, expected);
        end
    endtask

    // Behavioural model state
    int         mLast;
    bit         mPend;
    int         mPendCore;
    logic [7:0] mPendAddr;
    logic [7:0] mIns [4];
    logic [3:0] mValid;
    bit         mDone;
    int         mCount;
    logic [7:0] mLastAddr;

    always @(negedge clk) begin
        logic [3:0] act;
        int         g;
        logic [7:0] expAddr;
        if (insValid[3]) valid3Seen = 1'b1;
        if (!rst_n) begin
            mLast = 3; mPend = 0; mPendCore = 0; mPendAddr = 0;
            mValid = 0; mDone = 0; mCount = 0; mLastAddr = 0;
            for (int i = 0; i < 4; i++) mIns[i] = 0;
        end
        act = (coreSel >= 1 && coreSel <= 4) ? 4'((1 << coreSel) - 1) : 4'hF;
        g = -1;
        if (rst_n) begin
            for (int k = 1; k <= 4 && g < 0; k++) begin
                int c;
                c = (mLast + k) % 4;
                if (fetchReq[c] && act[c] && !endOp[c] && !(mPend && mPendCore == c)) g = c;
            end
        end
        expAddr = (g >= 0) ? fetchAddr[g*8 +: 8] : mLastAddr;
        checkOutput("mem_en", 32'(memEn), 32'(g >= 0));
        checkOutput("mem_addr", 32'(memAddr), 32'(expAddr));
        checkOutput("ins_valid", 32'(insValid), 32'(mValid));
        checkOutput("ins1", 32'(ins1), 32'(mIns[0]));
        checkOutput("ins2", 32'(ins2), 32'(mIns[1]));
        checkOutput("ins3", 32'(ins3), 32'(mIns[2]));
        checkOutput("ins4", 32'(ins4), 32'(mIns[3]));
        checkOutput("all_done", 32'(allDone), 32'(mDone));
        checkOutput("fetch_count", 32'(fetchCount), 32'(mCount));
        if (rst_n) begin
            mDone = ((endOp & act) == act) && !mPend && (g < 0);
            if (mPend) begin
                mIns[mPendCore] = mem[mPendAddr];
                mValid = 4'(1 << mPendCore);
            end else begin
                mValid = 0;
            end
            mPend = (g >= 0);
            if (g >= 0) begin
                mPendCore = g;
                mPendAddr = expAddr;
                mLast     = g;
                mLastAddr = expAddr;
                if (mCount < 65535) mCount++;
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] req, input logic [2:0] sel, input logic [3:0] eop);
        @(posedge clk);
        #1;
        fetchReq = req;
        coreSel  = sel;
        endOp    = eop;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        fetchReq = 4'b0000;
        endOp    = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0; cycle = 0; valid3Seen = 0;
        rst_n = 1'b0; coreSel = 3'd1; fetchReq = 0; endOp = 0; fetchAddr = 0; memRdata = 0;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a + 'h10);
        mem[5] = 8'hA3;

        repeat (3) @(posedge clk);
        #3;
        checkOutput("reset mem_en", 32'(memEn), 0);
        checkOutput("reset fetch_count", 32'(fetchCount), 0);
        checkOutput("reset all_done", 32'(allDone), 0);
        checkOutput("reset ins_valid", 32'(insValid), 0);
        #1 rst_n = 1'b1;

        // Single core fetch: 2-cycle latency
        fetchAddr = 32'h0000_0005;
        applyStimulus(4'b0001, 3'd1, 4'b0000);
        #2;
        checkOutput("t2 mem_en c0", 32'(memEn), 1);
        checkOutput("t2 mem_addr c0", 32'(memAddr), 32'h05);
        applyStimulus(4'b0001, 3'd1, 4'b0000);
        applyStimulus(4'b0000, 3'd1, 4'b0000);
        #2;
        checkOutput("t2 ins1 c2", 32'(ins1), 32'hA3);
        checkOutput("t2 ins_valid c2", 32'(insValid), 32'h1);
        applyStimulus(4'b0000, 3'd1, 4'b0000);

        // Four cores together, granted 0..3 back to back
        doReset();
        fetchAddr = 32'h2322_2120;
        applyStimulus(4'b1111, 3'd4, 4'b0000);
        #2 checkOutput("t3 grant c0", 32'(memAddr), 32'h20);
        applyStimulus(4'b1111, 3'd4, 4'b0000);
        #2 checkOutput("t3 grant c1", 32'(memAddr), 32'h21);
        applyStimulus(4'b1110, 3'd4, 4'b0000);
        #2 checkOutput("t3 grant c2", 32'(memAddr), 32'h22);
        checkOutput("t3 valid c2", 32'(insValid), 32'b0001);
        applyStimulus(4'b1100, 3'd4, 4'b0000);
        #2 checkOutput("t3 grant c3", 32'(memAddr), 32'h23);
        checkOutput("t3 valid c3", 32'(insValid), 32'b0010);
        applyStimulus(4'b1000, 3'd4, 4'b0000);
        #2 checkOutput("t3 valid c4", 32'(insValid), 32'b0100);
        checkOutput("t3 count", 32'(fetchCount), 4);
        applyStimulus(4'b0000, 3'd4, 4'b0000);
        #2 checkOutput("t3 valid c5", 32'(insValid), 32'b1000);
        checkOutput("t3 ins4", 32'(ins4), 32'h33);

        // Inactive core 3 never served
        doReset();
        valid3Seen = 0;
        for (int i = 0; i < 20; i++) applyStimulus(4'b1000, 3'd2, 4'b0000);
        #2;
        checkOutput("t4 ins4", 32'(ins4), 0);
        checkOutput("t4 valid3 seen", 32'(valid3Seen), 0);

        // Ended core skipped; all_done once every active core ends
        fetchAddr = 32'h0000_4140;
        applyStimulus(4'b0011, 3'd2, 4'b0010);
        #2 checkOutput("t5 grant core0", 32'(memAddr), 32'h40);
        applyStimulus(4'b0011, 3'd2, 4'b0010);
        #2 checkOutput("t5 core1 blocked", 32'(memEn), 0);
        applyStimulus(4'b0010, 3'd2, 4'b0010);
        #2 checkOutput("t5 ins1", 32'(ins1), 32'h50);
        applyStimulus(4'b0010, 3'd2, 4'b0010);
        #2 checkOutput("t5 all_done low", 32'(allDone), 0);
        applyStimulus(4'b0000, 3'd2, 4'b0011);
        applyStimulus(4'b0000, 3'd2, 4'b0011);
        #2 checkOutput("t5 all_done high", 32'(allDone), 1);
        checkOutput("t5 ins2", 32'(ins2), 0);

        // Reset in the middle of a grant cycle
        fetchAddr = 32'h6362_6160;
        applyStimulus(4'b1111, 3'd4, 4'b0000);
        #2 rst_n = 1'b0;
        applyStimulus(4'b1111, 3'd4, 4'b0000);
        applyStimulus(4'b0000, 3'd4, 4'b0000);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 3'd4, 4'b0000);
            #2 checkOutput("t6 no valid after reset", 32'(insValid), 0);
        end
        applyStimulus(4'b1111, 3'd4, 4'b0000);
        #2 checkOutput("t6 first grant core0", 32'(memAddr), 32'h60);

        // Sustained traffic with requests held through valid cycles
        fetchAddr = 32'h8a7b_6c5d;
        for (int i = 0; i < 30; i++) applyStimulus(4'b0111, 3'd3, 4'b0000);
        for (int i = 0; i < 12; i++) applyStimulus(4'b1111, 3'd0, 4'b0000);
        for (int i = 0; i < 8; i++)  applyStimulus(4'b1011, 3'd5, 4'b0100);
        for (int i = 0; i < 4; i++)  applyStimulus(4'b0000, 3'd5, 4'b1111);
        #2 checkOutput("t7 all_done", 32'(allDone), 1);
        applyStimulus(4'b0000, 3'd5, 4'b1110);
        applyStimulus(4'b0000, 3'd5, 4'b1110);
        #2 checkOutput("t7 all_done drop", 32'(allDone), 0);

        @(posedge clk);
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
